// File: rtl/sopc_2_pio_pkg.sv
// Shared definitions for the SOPC input PIO with edge capture and interrupt.
// Holds the Avalon register map, the edge-type encoding and the edge
// selection helper used by the top level.
package sopc_2_pio_pkg;

  // Avalon word addresses of the register file.
  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  // Width of the Avalon data bus.
  localparam int PIO_BUS_W = 32;

  // Which transitions of the filtered input latch into EDGECAP.
  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  // Per-bit edge pulses for the selected edge type. Operands are bus-wide so
  // the helper is independent of the instance width; callers zero-extend.
  // The unused encoding 3 behaves like EDGE_ANY.
  function automatic logic [PIO_BUS_W-1:0] pio_edge_select(
    input logic [PIO_BUS_W-1:0] filt,
    input logic [PIO_BUS_W-1:0] prev,
    input edge_type_e           etype
  );
    logic [PIO_BUS_W-1:0] rise;
    logic [PIO_BUS_W-1:0] fall;
    logic [PIO_BUS_W-1:0] sel;
    rise = filt & ~prev;
    fall = ~filt & prev;
    case (etype)
      EDGE_RISE: sel = rise;
      EDGE_FALL: sel = fall;
      default:   sel = rise | fall;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/sopc_2_pio_in_irq_debounce.sv
// Single-bit input conditioner: 2-FF synchroniser followed, when
// SOPC_2_PIO_IN_DEBOUNCE_EN is defined, by a stable-count debounce filter.
// Without the macro the synchronised value is passed straight through and no
// counter exists. Module name sopc_2_pio_debounce.
module sopc_2_pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic filt_o
);

  // The filter length is only meaningful inside 1..2^20; reject anything else
  // at elaboration so a bad build cannot silently produce a zero-length count.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_debounce
    $error("sopc_2_pio_debounce: DEBOUNCE_CYCLES out of range 1..2^20");
  end

  logic meta_q;
  logic sync_q;

  // Two-stage synchroniser for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= in_i;
      sync_q <= meta_q;
    end
  end

`ifdef SOPC_2_PIO_IN_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The counter value on the cycle that completes the stable window; the
  // update happens on that same edge, so the filtered output follows the
  // synchronised input after exactly DEBOUNCE_CYCLES mismatching cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             filt_q;
  logic             filt_d;

  // Count consecutive cycles where the input disagrees with the accepted
  // value; any agreeing cycle restarts the window.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;
`else
  assign filt_o = sync_q;
`endif

endmodule

// File: rtl/sopc_2_pio_in_irq.sv
// SOPC input PIO with per-bit edge capture and a maskable level interrupt.
// Register map: 0 DATA (RO), 1 reserved, 2 IRQMASK (RW), 3 EDGECAP (W1C).
// Optional input debounce is compiled in with SOPC_2_PIO_IN_DEBOUNCE_EN.
//
// Bus protocol: the slave has no waitrequest, so every cycle with write high
// is a completed write at that edge; reads are strobe-less, readdata always
// shows the register selected by the address sampled on the previous edge.
module sopc_2_pio_in_irq
  import sopc_2_pio_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int EDGE_TYPE       = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > PIO_BUS_W) begin : g_bad_width
    $error("sopc_2_pio_in_irq: WIDTH out of range 1..32");
  end
  if (EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_bad_edge
    $error("sopc_2_pio_in_irq: EDGE_TYPE must be 0, 1 or 2");
  end

  localparam edge_type_e EDGE_SEL = edge_type_e'(2'(EDGE_TYPE));

  logic [WIDTH-1:0]     filt;
  logic [WIDTH-1:0]     prev_q;
  logic [WIDTH-1:0]     irqmask_q;
  logic [WIDTH-1:0]     irqmask_d;
  logic [WIDTH-1:0]     edgecap_q;
  logic [WIDTH-1:0]     edgecap_d;
  logic [WIDTH-1:0]     edge_hit;
  logic [WIDTH-1:0]     cap_clr;
  logic [PIO_BUS_W-1:0] edge_all;
  logic [31:0]          readdata_q;
  logic [31:0]          readdata_d;
  logic                 irq_q;
  logic                 irq_d;
  logic                 wr_mask;
  logic                 wr_cap;
  logic                 unused_bits;

  // One synchroniser / debounce slice per input pin.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sopc_2_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .in_i  (in_port[i]),
      .filt_o(filt[i])
    );
  end

  // Edge detection against the previous filtered value.
  assign edge_all = pio_edge_select(PIO_BUS_W'(filt), PIO_BUS_W'(prev_q), EDGE_SEL);
  assign edge_hit = edge_all[WIDTH-1:0];

  assign wr_mask = write && (address == PIO_ADDR_IRQMASK);
  assign wr_cap  = write && (address == PIO_ADDR_EDGECAP);
  assign cap_clr = wr_cap ? writedata[WIDTH-1:0] : '0;

  // Bus bits above WIDTH and helper bits above WIDTH carry no meaning.
  assign unused_bits = ^{writedata, edge_all};

  // Register-file next state. A new edge is OR-ed in after the clear so a
  // set and a clear landing on the same bit in one cycle leave the flag set.
  always_comb begin
    irqmask_d = irqmask_q;
    if (wr_mask) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    edgecap_d = (edgecap_q & ~cap_clr) | edge_hit;
    irq_d     = |(edgecap_q & irqmask_q);
  end

  // Read mux; loaded every cycle, reads have no side effects.
  always_comb begin
    readdata_d = '0;
    case (address)
      PIO_ADDR_DATA:    readdata_d = 32'(filt);
      PIO_ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
      PIO_ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
      default:          readdata_d = '0;
    endcase
  end

  // All architectural state; reset discards everything, including flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q     <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      prev_q     <= filt;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: doc/sopc_2_pio_in_irq.md
# sopc_2_pio_in_irq

Parametrised Avalon-MM slave for general-purpose input pins (switches, keys, buttons). It synchronises an asynchronous `in_port` bus into the `clk` domain and latches selected edges per bit into an edge-capture register. It raises a maskable level interrupt toward the Nios II IRQ line. The block sits in the SOPC fabric alongside the other PIO peripherals and is a superset of the plain read-only input PIO.

## Interface
Parameters:
- `WIDTH`, 10: number of input bits; 1..32.
- `EDGE_TYPE`, 2: edges captured; 0 rising, 1 falling, 2 any.
- `DEBOUNCE_CYCLES`, 50000: stable cycles required before a bit is accepted. Used only when debounce is compiled in; legal range 1..2^20.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous reset, active-high; sampled on the rising edge of `clk`.
- `address`  in  2  Avalon word address.
- `write`  in  1  Avalon write strobe.
- `writedata`  in  32  Avalon write data.
- `readdata`  out  32  Avalon read data, registered; upper `32-WIDTH` bits are always 0.
- `in_port`  in  WIDTH  asynchronous pin inputs.
- `irq`  out  1  level interrupt, registered.

## Operation
- Register map:
  - 0 DATA (RO): filtered input value.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQMASK (RW): per-bit interrupt enable.
  - 3 EDGECAP (R/W1C): per-bit sticky edge flags.
- Input path: `in_port` passes through a 2-FF synchroniser to give `sync`. The optional debouncer then produces `filt`. `prev` holds the previous value of `filt`.
- Edge detect, per bit:
  - rise = `filt & ~prev`
  - fall = `~filt & prev`
  - selection follows `EDGE_TYPE`.
- EDGECAP bit update: set on a detected edge. Cleared when `write && address==3 && writedata[i]==1`. If a set and a clear hit the same bit in the same cycle, the set wins.
- IRQMASK is written in full on `write && address==2`; `writedata[31:WIDTH]` is ignored.
- `irq` is registered from `|(EDGECAP & IRQMASK)`.
- `readdata` is loaded every cycle from the address mux. There are no read strobes and reads have no side effects.
- Reset values: `readdata`=0, `irq`=0, IRQMASK=0, EDGECAP=0, synchroniser flops=0, `prev`=0, `filt`=0, debounce counters=0. The first post-reset sample of a high input therefore registers a rising edge; this is intended.
- Reset mid-operation (including mid-debounce) discards all state with no residual flags.

## Timing
- Read latency is 1 cycle: `readdata` reflects the `address` sampled on the previous edge.
- Without debounce, for `in_port` stable before edge k:
  - `sync` is valid after edge k+1.
  - DATA is visible in `readdata` after edge k+2 (with address=0 held).
  - EDGECAP is set at edge k+2.
  - `irq` asserts at edge k+3 if the mask bit is set.
- Writes take effect at the edge where `write` is sampled. A read of the same register on the next cycle returns the new value.
- Clearing EDGECAP drops `irq` one cycle after the clear edge, unless another masked flag is still set.

## Configuration
- Macro: `SOPC_2_PIO_IN_DEBOUNCE_EN`.
- Defined: each bit has a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - While `sync[i] != filt[i]`, the counter increments.
  - When it reaches `DEBOUNCE_CYCLES`, `filt[i]` takes `sync[i]` and the counter resets to 0.
  - Any cycle with `sync[i]==filt[i]` resets the counter to 0.
  - Total added latency is `DEBOUNCE_CYCLES` cycles.
- Undefined: `filt = sync` directly, no counters are instantiated, and `DEBOUNCE_CYCLES` is unused.

## Structure
- Package `sopc_2_pio_pkg`: register address constants (`PIO_ADDR_DATA`=0, `PIO_ADDR_IRQMASK`=2, `PIO_ADDR_EDGECAP`=3) and an edge-type enum (`EDGE_RISE`, `EDGE_FALL`, `EDGE_ANY`).
- Sub-module `sopc_2_pio_debounce`: single-bit synchroniser plus debounce counter, generate-instantiated `WIDTH` times.

## Test plan
- Reset with `in_port`=10'h3FF -> `readdata`=0 and `irq`=0 during reset; after release and a DATA read, `readdata`=32'h3FF. EDGECAP reads 32'h3FF (power-up rising edges).
- No debounce, `EDGE_TYPE`=0, IRQMASK=10'h001: pulse `in_port[0]` 0→1 -> EDGECAP[0] set 2 cycles later, `irq`=1 3 cycles after the input edge. Writing 32'h1 to address 3 drops `irq` on the next cycle.
- Same-cycle clear and new edge on bit 3 -> EDGECAP[3] remains 1.
- `EDGE_TYPE`=1: rising then falling on bit 5 -> only the fall sets EDGECAP[5]. Setting IRQMASK=0 keeps `irq`=0 throughout.
- `SOPC_2_PIO_IN_DEBOUNCE_EN` defined with `DEBOUNCE_CYCLES`=8: a 5-cycle glitch yields no DATA change and no EDGECAP bit; a 12-cycle high level updates DATA after 8 stable cycles.
- Write 32'hFFFF_FFFF to IRQMASK with `WIDTH`=10 -> IRQMASK reads back 32'h3FF; address 1 reads 0.
